// File: rtl/data_mem_responder_if.sv
// Load/store port between the core datapath (master) and the data memory (slave).
// Latency: wires only, no storage.
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Requester side: issues loads/stores, consumes responses.
  modport master (
    output req_valid, req_write, req_f3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Responder side: the memory.
  modport slave (
    input  req_valid, req_write, req_f3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time against a word array, RISC-V funct3 byte/half/word.
// Latency: response valid WAIT_CYCLES+1 edges after the accepting edge; one request in flight.
// Backpressure: req_ready only in IDLE; RESP holds data until rsp_ready. Macro MISALIGN_TRAP_EN traps misaligned H/W.
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_responder_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Latched request
  logic             wr_q;
  logic [2:0]       f3_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] cnt;

  // Registered response
  logic [31:0] rdata_q;
  logic        err_q;

  // Storage
  logic [31:0] mem [DEPTH];

  // Access datapath
  logic [DEPTH_LOG2-1:0] widx;
  logic [1:0]            lane;
  logic [31:0]           word_cur;
  logic [31:0]           shifted;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic                  f3_bad;
  logic                  misalign;
  logic                  err_nxt;
  logic [31:0]           rdata_nxt;
  logic [31:0]           wword_nxt;
  logic                  accept;
  logic                  done;
  logic                  do_write;

  assign widx     = addr_q[DEPTH_LOG2+1:2];
  assign lane     = addr_q[1:0];
  assign word_cur = mem[widx];
  assign accept   = (state == IDLE) && bus.req_valid;
  assign done     = (state == ACCESS) && (cnt == '0);
  assign do_write = done && wr_q && !err_nxt;

  // Decode legality, extract/extend load data, and merge store data into the addressed word.
  always_comb begin
    shifted   = word_cur >> {lane, 3'b000};
    byte_v    = shifted[7:0];
    half_v    = addr_q[1] ? word_cur[31:16] : word_cur[15:0];
    f3_bad    = 1'b0;
    misalign  = 1'b0;
    rdata_nxt = '0;
    wword_nxt = word_cur;

    // Unsigned variants only exist for loads; 011/110/111 are never valid.
    case (f3_q)
      3'b000, 3'b001, 3'b010: f3_bad = 1'b0;
      3'b100, 3'b101:         f3_bad = wr_q;
      default:                f3_bad = 1'b1;
    endcase

`ifdef MISALIGN_TRAP_EN
    misalign = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
               ((f3_q == 3'b010) && (addr_q[1:0] != 2'b00));
`else
    // Low address bits below the access size are simply ignored.
    misalign = 1'b0;
`endif

    err_nxt = f3_bad | misalign;

    if (!wr_q && !err_nxt) begin
      case (f3_q)
        3'b000:  rdata_nxt = {{24{byte_v[7]}}, byte_v};
        3'b100:  rdata_nxt = {24'h0, byte_v};
        3'b001:  rdata_nxt = {{16{half_v[15]}}, half_v};
        3'b101:  rdata_nxt = {16'h0, half_v};
        3'b010:  rdata_nxt = word_cur;
        default: rdata_nxt = '0;
      endcase
    end

    case (f3_q[1:0])
      2'b00: wword_nxt[{lane, 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (addr_q[1]) wword_nxt[31:16] = wdata_q[15:0];
        else           wword_nxt[15:0]  = wdata_q[15:0];
      end
      2'b10:   wword_nxt = wdata_q;
      default: wword_nxt = word_cur;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Capture the request on acceptance and count down the wait states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
    end else if (accept) begin
      wr_q    <= bus.req_write;
      f3_q    <= bus.req_f3;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      cnt     <= CNT_INIT;
    end else if ((state == ACCESS) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Response registers load once at completion and hold through any stall in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (done) begin
      rdata_q <= rdata_nxt;
      err_q   <= err_nxt;
    end
  end

  // Array: cleared by reset, written at the completing edge so later loads see the new data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_write) begin
      mem[widx] <= wword_nxt;
    end
  end

  // A stalled response must not change under the requester.
  a_rsp_stable: assert property (
    @(posedge clk) disable iff (!rst)
    (bus.rsp_valid && !bus.rsp_ready) |=>
      (bus.rsp_valid && $stable(bus.rsp_rdata) && $stable(bus.rsp_err))
  );

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  localparam int W  = 1;
  localparam int DL = 6;
  localparam int PERIOD = 10;

  logic clk;
  logic rst;

  data_mem_responder_if bus ();

  data_mem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    longint      t_acc;
    int          tag;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   seen   = 0;

  initial begin
    clk = 1'b0;
    forever #(PERIOD / 2) clk = ~clk;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endfunction

  // Scoreboard monitor: latency on first sight of a response, data/err at the handshake.
  always @(negedge clk) begin
    if (rst && bus.rsp_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b, required no response", bus.rsp_rdata, bus.rsp_err);
      end else begin
        if (!seen) begin
          seen = 1;
          chk($sformatf("latency[%0d]", sb[0].tag), 32'($time - sb[0].t_acc), 32'((W + 1) * PERIOD + PERIOD / 2));
        end
        if (bus.rsp_ready) begin
          cur = sb.pop_front();
          chk($sformatf("rdata[%0d]", cur.tag), bus.rsp_rdata, cur.rdata);
          chk($sformatf("err[%0d]", cur.tag), 32'(bus.rsp_err), 32'(cur.err));
          seen = 0;
        end
      end
    end
  end

  // Drive one request at the current negedge; it is accepted at the following posedge.
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input int tag, input bit push);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_f3    = f3;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    if (push) sb.push_back('{exp_rd, exp_err, longint'($time), tag});
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int tag, input bit push);
    int k = 0;
    @(negedge clk);
    while (!bus.req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("req_ready_wait[%0d]", tag), 32'(bus.req_ready), 32'd1);
    if (bus.req_ready) issue(wr, f3, addr, wdata, exp_rd, exp_err, tag, push);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_f3    = 3'b000;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    rst = 1'b0;

    #12;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // wr, f3, addr, wdata, expected rdata, expected err, tag, push
    do_req(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0, 1, 1);
    do_req(0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2, 1);
    do_req(1, 3'b000, 32'h21,  32'h80,       32'h0,        0, 3, 1);
    do_req(0, 3'b000, 32'h21,  32'h0,        32'hFFFFFF80, 0, 4, 1);
    do_req(0, 3'b100, 32'h21,  32'h0,        32'h00000080, 0, 5, 1);
    do_req(0, 3'b010, 32'h20,  32'h0,        32'h00008000, 0, 6, 1);
    do_req(0, 3'b000, 32'h23,  32'h0,        32'h0,        0, 7, 1);
    do_req(1, 3'b001, 32'h32,  32'h8001,     32'h0,        0, 8, 1);
    do_req(0, 3'b001, 32'h32,  32'h0,        32'hFFFF8001, 0, 9, 1);
    do_req(0, 3'b101, 32'h32,  32'h0,        32'h00008001, 0, 10, 1);
    do_req(0, 3'b010, 32'h30,  32'h0,        32'h80010000, 0, 11, 1);
    do_req(1, 3'b010, 32'h40,  32'hCAFEF00D, 32'h0,        0, 12, 1);
`ifdef MISALIGN_TRAP_EN
    do_req(0, 3'b010, 32'h41,  32'h0,        32'h0,        1, 13, 1);
`else
    do_req(0, 3'b010, 32'h41,  32'h0,        32'hCAFEF00D, 0, 13, 1);
`endif
    do_req(1, 3'b100, 32'h40,  32'hFFFFFFFF, 32'h0,        1, 14, 1);
    do_req(0, 3'b011, 32'h40,  32'h0,        32'h0,        1, 15, 1);
    do_req(0, 3'b010, 32'h40,  32'h0,        32'hCAFEF00D, 0, 16, 1);
    do_req(0, 3'b010, 32'h110, 32'h0,        32'hDEADBEEF, 0, 17, 1);
    do_req(1, 3'b000, 32'h22,  32'hFFFFFF55, 32'h0,        0, 18, 1);
    do_req(0, 3'b010, 32'h20,  32'h0,        32'h00558000, 0, 19, 1);
    wait_drain("drain_directed");

    // Stall in RESP; a store presented meanwhile must be ignored.
    bus.rsp_ready = 1'b0;
    do_req(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 20, 1);
    k = 0;
    while (!bus.rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("stall_rsp_seen", 32'(bus.rsp_valid), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_f3    = 3'b010;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_rsp_valid[%0d]", i), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("stall_rdata[%0d]", i), bus.rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("stall_req_ready[%0d]", i), 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_stall_req_ready", 32'(bus.req_ready), 32'd1);
    issue(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 21, 1);
    wait_drain("drain_stall");

    // Reset while a store is in ACCESS: store dropped, array cleared.
    do_req(1, 3'b010, 32'h8, 32'h12345678, 32'h0, 0, 99, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("midrst_rsp_err",   32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    do_req(0, 3'b010, 32'h8,  32'h0, 32'h0, 0, 22, 1);
    do_req(0, 3'b010, 32'h10, 32'h0, 32'h0, 0, 23, 1);
    wait_drain("drain_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
